// File: rtl/mdr_pkg.sv
// Shared types for the MDR error monitor: opcodes, error causes and monitor states.
package mdr_pkg;

  typedef enum logic [1:0] {
    OpMul  = 2'd0,
    OpDiv  = 2'd1,
    OpSqrt = 2'd2,
    OpRsvd = 2'd3
  } opcode_e;

  typedef enum logic [2:0] {
    ErrNone      = 3'd0,
    ErrMulOvf    = 3'd1,
    ErrDivZero   = 3'd2,
    ErrSqrtNeg   = 3'd3,
    ErrIllegalOp = 3'd4
  } err_code_e;

  typedef logic [2:0] state_t;

  localparam state_t StIdle      = 3'd0;
  localparam state_t StOperandA  = 3'd1;
  localparam state_t StOperandB  = 3'd2;
  localparam state_t StWaitReady = 3'd3;
  localparam state_t StError     = 3'd4;

endpackage

// File: rtl/mdr_error_monitor_if.sv
// Snooped MDR control signals plus the monitor's status outputs.
interface mdr_error_monitor_if #(
  parameter int unsigned WORD_LENGTH = 16,
  parameter int unsigned COUNT_WIDTH = 8
);
  logic                   start;
  logic                   load_data;
  logic                   ready;
  logic [1:0]             opcode;
  logic [WORD_LENGTH-1:0] data;
  logic                   clear_error;
  logic                   error;
  logic [2:0]             error_code;
  logic [COUNT_WIDTH-1:0] error_count;
  logic                   busy;

  modport master (
    output start, load_data, ready, opcode, data, clear_error,
    input  error, error_code, error_count, busy
  );

  modport slave (
    input  start, load_data, ready, opcode, data, clear_error,
    output error, error_code, error_count, busy
  );
endinterface

// File: rtl/mdr_operand_check.sv
// Combinational per-opcode operand legality check for one operand slot.
module mdr_operand_check
  import mdr_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 16,
  parameter int unsigned MUL_LIMIT   = 32768
) (
  input  opcode_e                opcode_i,
  input  logic                   operand_b_i,
  input  logic [WORD_LENGTH-1:0] data_i,
  output logic                   violation_o,
  output err_code_e              code_o
);

  localparam int unsigned CmpW = (WORD_LENGTH > 32) ? WORD_LENGTH : 32;

  logic [CmpW-1:0] data_ext;
  logic [CmpW-1:0] limit_ext;

  assign data_ext  = CmpW'(data_i);
  assign limit_ext = CmpW'(MUL_LIMIT);

  always_comb begin
    violation_o = 1'b0;
    code_o      = ErrNone;
    unique case (opcode_i)
      OpMul: begin
        if (data_ext > limit_ext) begin
          violation_o = 1'b1;
          code_o      = ErrMulOvf;
        end
      end
      OpDiv: begin
        // Only the divisor (second operand) can be illegal.
        if (operand_b_i && (data_i == '0)) begin
          violation_o = 1'b1;
          code_o      = ErrDivZero;
        end
      end
      OpSqrt: begin
        if (!operand_b_i && data_i[WORD_LENGTH-1]) begin
          violation_o = 1'b1;
          code_o      = ErrSqrtNeg;
        end
      end
      OpRsvd: begin
        violation_o = 1'b1;
        code_o      = ErrIllegalOp;
      end
    endcase
  end

endmodule

// File: rtl/mdr_error_monitor.sv
// Tracks MDR operations start->operands->ready, flags illegal operands and
// keeps a saturating count of error entries.
module mdr_error_monitor
  import mdr_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 16,
  parameter int unsigned MUL_LIMIT   = 32768,
  parameter int unsigned COUNT_WIDTH = 8,
  parameter bit          STICKY      = 1'b1
) (
  input logic               clk,
  input logic               reset,
  mdr_error_monitor_if.slave bus
);

  state_t                 state_q, state_d;
  opcode_e                opcode_q, opcode_d;
  err_code_e              code_q, code_d;
  logic                   error_q, error_d;
  logic                   busy_q, busy_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   enter_err;
  logic                   chk_viol;
  err_code_e              chk_code;
  opcode_e                start_op;

  assign start_op = opcode_e'(bus.opcode);

  mdr_operand_check #(
    .WORD_LENGTH (WORD_LENGTH),
    .MUL_LIMIT   (MUL_LIMIT)
  ) u_check (
    .opcode_i    (opcode_q),
    .operand_b_i (state_q == StOperandB),
    .data_i      (bus.data),
    .violation_o (chk_viol),
    .code_o      (chk_code)
  );

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    code_d    = code_q;
    enter_err = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          opcode_d = start_op;
          if (start_op == OpRsvd) begin
            state_d   = StError;
            code_d    = ErrIllegalOp;
            enter_err = 1'b1;
          end else begin
            state_d = StOperandA;
          end
        end
      end
      StOperandA: begin
        if (bus.load_data) begin
          if (chk_viol) begin
            state_d   = StError;
            code_d    = chk_code;
            enter_err = 1'b1;
          end else if (opcode_q == OpSqrt) begin
            state_d = StWaitReady;
          end else begin
            state_d = StOperandB;
          end
        end
      end
      StOperandB: begin
        if (bus.load_data) begin
          if (chk_viol) begin
            state_d   = StError;
            code_d    = chk_code;
            enter_err = 1'b1;
          end else begin
            state_d = StWaitReady;
          end
        end
      end
      StWaitReady: begin
        if (bus.ready) begin
          state_d = StIdle;
        end
      end
      StError: begin
        if (bus.clear_error) begin
          state_d = StIdle;
          code_d  = ErrNone;
        end else if (!STICKY && bus.start) begin
          // Non-sticky: a start is handled exactly as from idle.
          opcode_d = start_op;
          if (start_op == OpRsvd) begin
            code_d    = ErrIllegalOp;
            enter_err = 1'b1;
          end else begin
            state_d = StOperandA;
            code_d  = ErrNone;
          end
        end
      end
      default: begin
        state_d = StIdle;
        code_d  = ErrNone;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (enter_err && (count_q != '1)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
    error_d = (state_d == StError);
    busy_d  = (state_d == StOperandA) || (state_d == StOperandB) || (state_d == StWaitReady);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      opcode_q <= OpMul;
      code_q   <= ErrNone;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      code_q   <= code_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
    end
  end

  assign bus.error       = error_q;
  assign bus.error_code  = code_q;
  assign bus.error_count = count_q;
  assign bus.busy        = busy_q;

endmodule
